// File: rtl/gemm_pkg.sv
// Shared state encoding and counter-width helper for the GEMM stream engine.
package gemm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        DRAIN
    } state_t;

    // Ceiling log2, never less than 1 so a dimension of 1 still gets a real counter bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/gemm_mac.sv
// Multiply-accumulate unit: one product per enabled cycle into a registered accumulator.
module gemm_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  clr_load,
    input  logic                  en,
    output logic [ACC_WIDTH-1:0]  sum
);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    ext;
    logic [ACC_WIDTH-1:0]    acc;

    // Product and its extension to accumulator width; sum is the value acc takes when enabled.
    always_comb begin
        if (SIGNED != 0) begin
            prod = $signed(a) * $signed(b);
            ext  = ACC_WIDTH'($signed(prod));
        end else begin
            prod = a * b;
            ext  = ACC_WIDTH'(prod);
        end
        sum = clr_load ? ext : acc + ext;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/gemm_stream_engine.sv
// Streaming GEMM engine: loads A then B from one word stream, runs one MAC per cycle,
// and emits C row-major through a one-entry result slot with backpressure.
module gemm_stream_engine
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int SIGNED     = 1,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  ovf
);

    localparam int unsigned IW = clog2(M);
    localparam int unsigned JW = clog2(N);
    localparam int unsigned KW = clog2(K);
    localparam int unsigned AW = clog2(M * K);
    localparam int unsigned BW = clog2(K * N);
    localparam int unsigned CW = clog2((M * K > K * N) ? M * K : K * N);

    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [CW-1:0] A_LAST = CW'(M * K - 1);
    localparam logic [CW-1:0] B_LAST = CW'(K * N - 1);

    state_t state, state_nxt;

    logic [CW-1:0]         in_cnt;
    logic [IW-1:0]         i_idx;
    logic [JW-1:0]         j_idx;
    logic [KW-1:0]         k_idx;
    logic [DATA_WIDTH-1:0] a_mem [M*K];
    logic [DATA_WIDTH-1:0] b_mem [K*N];

    logic                  in_fire, out_fire;
    logic                  k_last, elem_last, mac_en, slot_wr;
    logic [ACC_WIDTH-1:0]  sum;
    logic [DATA_WIDTH-1:0] red_data;
    logic                  red_ovf;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign k_last    = (k_idx == K_LAST);
    assign elem_last = (i_idx == I_LAST) && (j_idx == J_LAST);
    // The MAC only stalls on the cycle that would complete an element into a slot that stays full.
    assign mac_en    = (state == COMPUTE) && (!k_last || !out_valid || out_ready);
    assign slot_wr   = mac_en && k_last;

    gemm_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED     (SIGNED)
    ) u_mac (
        .clk      (clk),
        .reset_n  (reset_n),
        .a        (a_mem[AW'(i_idx * K + k_idx)]),
        .b        (b_mem[BW'(k_idx * N + j_idx)]),
        .clr_load (k_idx == '0),
        .en       (mac_en),
        .sum      (sum)
    );

    // Reduce the accumulator to a result word; the same bits flag both clamp and truncation loss.
    always_comb begin
        red_data = sum[DATA_WIDTH-1:0];
        if (SIGNED != 0) begin
            red_ovf = !(&sum[ACC_WIDTH-1:DATA_WIDTH-1]) && (|sum[ACC_WIDTH-1:DATA_WIDTH-1]);
            if ((SATURATE != 0) && red_ovf) begin
                red_data = sum[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end else begin
            red_ovf = |sum[ACC_WIDTH-1:DATA_WIDTH];
            if ((SATURATE != 0) && red_ovf) begin
                red_data = '1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD_A;
            LOAD_A:  if (in_fire && in_cnt == A_LAST) state_nxt = LOAD_B;
            LOAD_B:  if (in_fire && in_cnt == B_LAST) state_nxt = COMPUTE;
            COMPUTE: if (slot_wr && elem_last) state_nxt = DRAIN;
            DRAIN:   if (out_fire && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, result slot, sticky overflow and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_cnt    <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && out_fire && out_last;
            if (state == IDLE && start) begin
                in_cnt <= '0;
                i_idx  <= '0;
                j_idx  <= '0;
                k_idx  <= '0;
                ovf    <= 1'b0;
            end
            if (in_fire) begin
                if ((state == LOAD_A && in_cnt == A_LAST) || (state == LOAD_B && in_cnt == B_LAST)) begin
                    in_cnt <= '0;
                end else begin
                    in_cnt <= in_cnt + 1'b1;
                end
            end
            if (mac_en) begin
                if (!k_last) begin
                    k_idx <= k_idx + 1'b1;
                end else begin
                    k_idx <= '0;
                    if (j_idx != J_LAST) begin
                        j_idx <= j_idx + 1'b1;
                    end else begin
                        j_idx <= '0;
                        i_idx <= (i_idx == I_LAST) ? '0 : i_idx + 1'b1;
                    end
                end
            end
            // A write wins over a drain in the same cycle, so the slot refills with no bubble.
            if (slot_wr) begin
                out_valid <= 1'b1;
                out_data  <= red_data;
                out_last  <= elem_last;
                if (red_ovf) ovf <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Operand buffers; contents need no reset.
    always_ff @(posedge clk) begin
        if (in_fire && state == LOAD_A) a_mem[in_cnt[AW-1:0]] <= in_data;
        if (in_fire && state == LOAD_B) b_mem[in_cnt[BW-1:0]] <= in_data;
    end

endmodule

// File: tb/tb_gemm_stream_engine.sv
// Directed bench for gemm_stream_engine, M=K=N=2, DW=16, signed, with a saturating and a
// truncating instance sharing the same stimulus.
module tb_gemm_stream_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = '0;

    logic        busy, done, in_ready, out_valid, out_last, ovf;
    logic [15:0] out_data;
    logic        t_busy, t_done, t_in_ready, t_out_valid, t_out_last, t_ovf;
    logic [15:0] t_out_data;

    int n_vec = 0;
    int n_err = 0;

    gemm_stream_engine #(
        .DATA_WIDTH (16), .ACC_WIDTH (40), .M (2), .K (2), .N (2), .SIGNED (1), .SATURATE (1)
    ) dut (
        .clk (clk), .reset_n (reset_n), .start (start), .busy (busy), .done (done),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .out_last (out_last), .ovf (ovf)
    );

    gemm_stream_engine #(
        .DATA_WIDTH (16), .ACC_WIDTH (40), .M (2), .K (2), .N (2), .SIGNED (1), .SATURATE (0)
    ) dut_t (
        .clk (clk), .reset_n (reset_n), .start (start), .busy (t_busy), .done (t_done),
        .in_valid (in_valid), .in_ready (t_in_ready), .in_data (in_data),
        .out_valid (t_out_valid), .out_ready (out_ready), .out_data (t_out_data),
        .out_last (t_out_last), .ovf (t_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic feed_word(input logic [15:0] w, input bit gaps, input bit noise);
        int t;
        @(negedge clk);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        if (noise) start = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic load_job(input logic [63:0] a, input logic [63:0] b, input bit gaps, input bit noise);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ovf_clr", ovf, 0);
        for (int i = 0; i < 4; i++) feed_word(a[i*16 +: 16], gaps, 1'b0);
        for (int i = 0; i < 4; i++) feed_word(b[i*16 +: 16], gaps, noise && (i == 1));
    endtask

    task automatic run_job(input string nm, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] es, input logic [63:0] et, input bit eo,
                           input bit gaps, input bit bp, input bit noise, input bit lat_chk);
        int          got, cyc, lat;
        bit          held;
        logic [15:0] held_data;
        logic        held_last;
        out_ready = bp ? 1'b0 : 1'b1;
        load_job(a, b, gaps, noise);
        if (lat_chk) begin
            lat = 0;
            @(negedge clk);
            while (!out_valid && lat < 20) begin
                lat++;
                @(negedge clk);
            end
            check({nm, "_first_latency"}, lat, 2);
        end else begin
            @(negedge clk);
        end
        got  = 0;
        cyc  = 0;
        held = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        while (got < 4 && cyc < 400) begin
            start     = noise && (cyc == 0);
            out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (held) begin
                check({nm, "_stall_valid"}, out_valid, 1);
                check({nm, "_stall_data"}, out_data, held_data);
                check({nm, "_stall_last"}, out_last, held_last);
                held = 1'b0;
            end
            if (out_valid) begin
                if (out_ready) begin
                    check($sformatf("%s_out%0d", nm, got), out_data, es[got*16 +: 16]);
                    check($sformatf("%s_tout%0d", nm, got), t_out_data, et[got*16 +: 16]);
                    check($sformatf("%s_last%0d", nm, got), out_last, (got == 3) ? 1 : 0);
                    got++;
                end else begin
                    held      = 1'b1;
                    held_data = out_data;
                    held_last = out_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({nm, "_count"}, got, 4);
        check({nm, "_done"}, done, 1);
        check({nm, "_busy_end"}, busy, 0);
        check({nm, "_no_extra"}, out_valid, 0);
        check({nm, "_ovf"}, ovf, eo);
        check({nm, "_tovf"}, t_ovf, eo);
        @(negedge clk);
        check({nm, "_done_pulse"}, done, 0);
    endtask

    localparam logic [63:0] A_BASIC = {16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [63:0] B_BASIC = {16'd8, 16'd7, 16'd6, 16'd5};
    localparam logic [63:0] C_BASIC = {16'd50, 16'd43, 16'd22, 16'd19};
    localparam logic [63:0] A_SGN   = {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    localparam logic [63:0] B_SGN   = {16'd6, 16'd5, 16'hFFFC, 16'd3};
    localparam logic [63:0] C_SGN   = {16'hFFFA, 16'hFFFB, 16'h0004, 16'hFFFD};
    localparam logic [63:0] X_MAX   = {4{16'h7FFF}};
    localparam logic [63:0] C_TRUNC = {4{16'h0002}};

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_ovf", ovf, 0);
        reset_n = 1'b1;

        run_job("basic",  A_BASIC, B_BASIC, C_BASIC, C_BASIC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_job("signed", A_SGN,   B_SGN,   C_SGN,   C_SGN,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job("sat",    X_MAX,   X_MAX,   X_MAX,   C_TRUNC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job("restart_noise", A_BASIC, B_BASIC, C_BASIC, C_BASIC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_job("bp_basic",  A_BASIC, B_BASIC, C_BASIC, C_BASIC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_job("bp_signed", A_SGN,   B_SGN,   C_SGN,   C_SGN,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset while the first result sits stalled in the slot.
        out_ready = 1'b0;
        load_job(X_MAX, X_MAX, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_ovf", ovf, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("post_rst_quiet", seen, 0);

        run_job("after_rst", A_BASIC, B_BASIC, C_BASIC, C_BASIC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
